// File: rtl/sram_arbiter.sv
// sram_arbiter: three-client arbiter in front of a single-port SRAM controller.
//
// Clients: VGA (read-only, strict top priority), UART (write-only) and AUX (read or write).
// Ownership is registered: a request seen in cycle N is granted no earlier than cycle N+1.
// An access goes to the SRAM only while the owner's request is still high. Each issued read
// pushes a tag through a READ_LATENCY-deep pipe so read data can be attributed to its client.
//
// Build option: define SRAM_ARB_ROUND_ROBIN_EN to alternate UART/AUX when both are pending at
// a decision point (UART wins first after reset). Default is fixed VGA > UART > AUX.
//
// Ports:
//   Clock, Reset                     rising-edge clock, synchronous active-high reset
//   VGA_req / VGA_address            VGA read request
//   UART_req / UART_address / _data  UART write request
//   AUX_req / AUX_we_n / AUX_*       auxiliary request, AUX_we_n=1 read, 0 write
//   *_grant                          client owns the SRAM this cycle
//   VGA_data_valid / AUX_data_valid  SRAM_read_data belongs to this client this cycle
//   SRAM_address/_write_data/_we_n   access to the SRAM controller (idle: 0 / 0 / 1)
//   SRAM_read_data                   read data from the controller, consumed by the clients
module sram_arbiter #(
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        VGA_req,
    input  logic [17:0] VGA_address,
    input  logic        UART_req,
    input  logic [17:0] UART_address,
    input  logic [15:0] UART_write_data,
    input  logic        AUX_req,
    input  logic        AUX_we_n,
    input  logic [17:0] AUX_address,
    input  logic [15:0] AUX_write_data,
    output logic        VGA_grant,
    output logic        UART_grant,
    output logic        AUX_grant,
    output logic        VGA_data_valid,
    output logic        AUX_data_valid,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n,
    input  logic [15:0] SRAM_read_data
);

    typedef enum logic [1:0] {
        S_ARB_IDLE,
        S_ARB_VGA,
        S_ARB_UART,
        S_ARB_AUX
    } arb_state_e;

    localparam logic [1:0] TagNone = 2'd0;
    localparam logic [1:0] TagVga  = 2'd1;
    localparam logic [1:0] TagAux  = 2'd2;

    arb_state_e state_q, state_d;
    logic [READ_LATENCY-1:0][1:0] tag_q;
    logic [1:0] push_tag;
    logic       owner_keeps;
    arb_state_e pick;

    // Read data is consumed by the clients directly; the arbiter only tags it.
    logic unused_read_data;
    assign unused_read_data = ^SRAM_read_data;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    // Set when AUX won the most recent UART/AUX decision; resets to AUX so UART goes first.
    logic last_aux_q, last_aux_d;

    always_comb begin
        last_aux_d = last_aux_q;
        if (state_d != state_q) begin
            if (state_d == S_ARB_UART) last_aux_d = 1'b0;
            if (state_d == S_ARB_AUX)  last_aux_d = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) last_aux_q <= 1'b1;
        else       last_aux_q <= last_aux_d;
    end
`endif

    // Next owner among UART/AUX when the bus is up for grabs.
    always_comb begin
        pick = S_ARB_IDLE;
        if (UART_req && AUX_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            pick = last_aux_q ? S_ARB_UART : S_ARB_AUX;
`else
            pick = S_ARB_UART;
`endif
        end else if (UART_req) begin
            pick = S_ARB_UART;
        end else if (AUX_req) begin
            pick = S_ARB_AUX;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_keeps = 1'b0;
        case (state_q)
            S_ARB_UART: owner_keeps = UART_req;
            S_ARB_AUX:  owner_keeps = AUX_req;
            default:    owner_keeps = 1'b0;
        endcase
        if (VGA_req)          state_d = S_ARB_VGA;
        else if (!owner_keeps) state_d = pick;
    end

    // Grants decode the owner; an access is issued only while the owner still requests.
    always_comb begin
        VGA_grant       = 1'b0;
        UART_grant      = 1'b0;
        AUX_grant       = 1'b0;
        SRAM_address    = '0;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        push_tag        = TagNone;
        unique case (state_q)
            S_ARB_VGA: begin
                VGA_grant = 1'b1;
                if (VGA_req) begin
                    SRAM_address = VGA_address;
                    push_tag     = TagVga;
                end
            end
            S_ARB_UART: begin
                UART_grant = 1'b1;
                if (UART_req) begin
                    SRAM_address    = UART_address;
                    SRAM_write_data = UART_write_data;
                    SRAM_we_n       = 1'b0;
                end
            end
            S_ARB_AUX: begin
                AUX_grant = 1'b1;
                if (AUX_req) begin
                    SRAM_address = AUX_address;
                    SRAM_we_n    = AUX_we_n;
                    if (AUX_we_n) push_tag        = TagAux;
                    else          SRAM_write_data = AUX_write_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= S_ARB_IDLE;
            tag_q   <= '0;
        end else begin
            state_q  <= state_d;
            tag_q[0] <= push_tag;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign VGA_data_valid = (tag_q[READ_LATENCY-1] == TagVga);
    assign AUX_data_valid = (tag_q[READ_LATENCY-1] == TagAux);

endmodule
